// File: rtl/bpm_uart_pkg.sv
// Shared types, ASCII constants and the binary-to-BCD helper for the BPM UART reporter.
package bpm_uart_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_LOAD,
        RPT_SEND
    } rpt_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Double-dabble: returns {hundreds, tens, ones} as three BCD nibbles.
    function automatic logic [11:0] bin_to_bcd(input logic [7:0] bin);
        logic [19:0] sr;
        sr = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sr[11:8] >= 4'd5)
                sr[11:8] = sr[11:8] + 4'd3;
            if (sr[15:12] >= 4'd5)
                sr[15:12] = sr[15:12] + 4'd3;
            if (sr[19:16] >= 4'd5)
                sr[19:16] = sr[19:16] + 4'd3;
            sr = sr << 1;
        end
        return sr[19:8];
    endfunction

endpackage

// File: rtl/bpm_uart_reporter_uart_tx_byte.sv
// 8N1 byte serializer. A start request in the last STOP cycle chains the next
// character with no idle gap.
module uart_tx_byte
    import bpm_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign done    = (state_q == TX_STOP) && bit_end;
    assign tx      = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            TX_IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (start) begin
                    state_d = TX_START;
                    shift_d = data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (start) begin
                        state_d = TX_START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/bpm_uart_reporter.sv
// Captures BPM values from the DigitalBlock handshake into a FIFO and reports
// each one as a decimal ASCII line (LF-terminated) over the UART.
module bpm_uart_reporter
    import bpm_uart_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [7:0]                    bpm_value,
    input  logic                          bpm_valid,
    output logic                          bpm_copied,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    rpt_state_e       state_q, state_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             armed_q, armed_d;
    logic             copied_q, copied_d;
    logic             busy_q, busy_d;
    logic [7:0]       chars_q [4];
    logic [7:0]       chars_d [4];
    logic [1:0]       char_idx_q, char_idx_d;
    logic [1:0]       last_idx_q, last_idx_d;

    logic [11:0]      bcd_c;
    logic [7:0]       hund_c, tens_c, ones_c;
    logic [7:0]       list_c [4];
    logic [1:0]       last_c;
    logic [1:0]       next_idx;
    logic             capture, pop;
    logic             tx_start, tx_done;
    logic [7:0]       tx_data;

    // Character list for the FIFO head, with leading zeros suppressed.
    always_comb begin
        bcd_c  = bin_to_bcd(mem_q[rd_ptr_q]);
        hund_c = ASCII_ZERO + {4'd0, bcd_c[11:8]};
        tens_c = ASCII_ZERO + {4'd0, bcd_c[7:4]};
        ones_c = ASCII_ZERO + {4'd0, bcd_c[3:0]};
        for (int i = 0; i < 4; i++)
            list_c[i] = ASCII_LF;
        last_c = 2'd1;
        if (bcd_c[11:8] != 4'd0) begin
            list_c[0] = hund_c;
            list_c[1] = tens_c;
            list_c[2] = ones_c;
            last_c    = 2'd3;
        end else if (bcd_c[7:4] != 4'd0) begin
            list_c[0] = tens_c;
            list_c[1] = ones_c;
            last_c    = 2'd2;
        end else begin
            list_c[0] = ones_c;
        end
    end

    assign next_idx = char_idx_q + 2'd1;

    always_comb begin
        capture    = en && bpm_valid && armed_q && (level_q != LVL_FULL);
        pop        = (state_q == RPT_LOAD);
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        armed_d    = armed_q;
        copied_d   = capture;
        busy_d     = busy_q;
        chars_d    = chars_q;
        char_idx_d = char_idx_q;
        last_idx_d = last_idx_q;
        tx_start   = 1'b0;
        tx_data    = chars_q[next_idx];

        if (capture) begin
            mem_d[wr_ptr_q] = bpm_value;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            armed_d         = 1'b0;
        end else if (!bpm_valid) begin
            armed_d = 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        level_d = level_q + LVL_W'(capture) - LVL_W'(pop);

        case (state_q)
            RPT_IDLE: begin
                if (level_q != '0)
                    state_d = RPT_LOAD;
            end
            RPT_LOAD: begin
                chars_d    = list_c;
                last_idx_d = last_c;
                char_idx_d = 2'd0;
                busy_d     = 1'b1;
                tx_start   = 1'b1;
                tx_data    = list_c[0];
                state_d    = RPT_SEND;
            end
            RPT_SEND: begin
                if (tx_done) begin
                    if (char_idx_q == last_idx_q) begin
                        busy_d  = 1'b0;
                        state_d = RPT_IDLE;
                    end else begin
                        char_idx_d = next_idx;
                        tx_start   = 1'b1;
                    end
                end
            end
            default: state_d = RPT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RPT_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            armed_q    <= 1'b1;
            copied_q   <= 1'b0;
            busy_q     <= 1'b0;
            char_idx_q <= 2'd0;
            last_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            armed_q    <= armed_d;
            copied_q   <= copied_d;
            busy_q     <= busy_d;
            char_idx_q <= char_idx_d;
            last_idx_q <= last_idx_d;
        end
        mem_q   <= mem_d;
        chars_q <= chars_d;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .start(tx_start),
        .data (tx_data),
        .tx   (uart_tx),
        .done (tx_done)
    );

    assign bpm_copied = copied_q;
    assign tx_busy    = busy_q;
    assign fifo_level = level_q;

endmodule
